alu8_cmd_issuer: RTL and testbench

//  Initiator side of the 8-bit ALU operand/result interface. Accepts commands (A, B, opcode, tag)

---
 rtl/alu8_pkg.sv | 27 ++
 rtl/alu8_cmd_issuer_sync_fifo.sv | 70 +++++++
 rtl/alu8_cmd_issuer.sv | 152 +++++++++++++++
 tb/tb_alu8_cmd_issuer.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu8_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu8_pkg
// Description : Opcodes, issuer FSM states and constants shared by the ALU8
//               command issuer and its sub-blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package alu8_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;
    localparam logic [2:0] OP_NOP = 3'b111;

    localparam logic [7:0] DIV_ZERO_RESULT = 8'hFF;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        SETTLE  = 3'd2,
        CAPTURE = 3'd3,
        RESP    = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/alu8_cmd_issuer_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with registered not-full flag and
//               combinational head read.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty,
    output logic             o_not_full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] C_DEPTH = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic [AW:0]      w_count_nxt;
    logic             r_not_full;
    logic             w_do_push;
    logic             w_do_pop;

    // A pop in the same cycle frees the slot, so a push while full is legal
    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && (r_not_full || w_do_pop);

    always_comb begin
        w_count_nxt = r_count;
        case ({w_do_push, w_do_pop})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_not_full <= 1'b1;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count    <= w_count_nxt;
            r_not_full <= (w_count_nxt != C_DEPTH);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_data     = r_mem[r_rd_ptr];
    assign o_empty    = (r_count == '0);
    assign o_not_full = r_not_full;

endmodule
`default_nettype wire

// File: rtl/alu8_cmd_issuer.sv
`default_nettype none
// ============================================================================
// Module      : alu8_cmd_issuer
// Description : Queues ALU8 commands, drives operands for a settle window and
//               returns the captured result with tag and divide-by-zero flag.
// Revision    : 1.0 - initial release
// ============================================================================
module alu8_cmd_issuer
    import alu8_pkg::*;
#(
    parameter int FIFO_DEPTH    = 4,
    parameter int SETTLE_CYCLES = 1,
    parameter int TAG_W         = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [7:0]       cmd_a,
    input  logic [7:0]       cmd_b,
    input  logic [2:0]       cmd_op,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic [7:0]       alu_a,
    output logic [7:0]       alu_b,
    output logic [2:0]       alu_op,
    input  logic [7:0]       alu_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [7:0]       rsp_data,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_err,
    output logic             busy
);

    localparam int FIFO_W = 8 + 8 + 3 + TAG_W;
    localparam int CNT_W  = $clog2(SETTLE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] C_SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_pop;
    logic                w_push;
    logic                w_fifo_empty;
    logic                w_fifo_not_full;
    logic [FIFO_W-1:0]   w_fifo_rdata;

    logic [7:0]          r_op_a;
    logic [7:0]          r_op_b;
    logic [2:0]          r_op_op;
    logic [TAG_W-1:0]    r_op_tag;
    logic [CNT_W-1:0]    r_settle_cnt;

    logic [7:0]          r_alu_a;
    logic [7:0]          r_alu_b;
    logic [2:0]          r_alu_op;
    logic                r_rsp_valid;
    logic [7:0]          r_rsp_data;
    logic [TAG_W-1:0]    r_rsp_tag;
    logic                r_rsp_err;

    assign w_push = cmd_valid && w_fifo_not_full;

    sync_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_push),
        .i_data     ({cmd_a, cmd_b, cmd_op, cmd_tag}),
        .i_pop      (w_pop),
        .o_data     (w_fifo_rdata),
        .o_empty    (w_fifo_empty),
        .o_not_full (w_fifo_not_full)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE:   w_state_nxt = SETTLE;
            SETTLE:  if (r_settle_cnt == '0) w_state_nxt = CAPTURE;
            CAPTURE: w_state_nxt = RESP;
            RESP:    if (rsp_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Operands stay on the ALU between commands; only reset parks it on NOP
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op_a       <= '0;
            r_op_b       <= '0;
            r_op_op      <= '0;
            r_op_tag     <= '0;
            r_settle_cnt <= '0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_op     <= OP_NOP;
            r_rsp_valid  <= 1'b0;
            r_rsp_data   <= '0;
            r_rsp_tag    <= '0;
            r_rsp_err    <= 1'b0;
        end else begin
            if (w_pop) {r_op_a, r_op_b, r_op_op, r_op_tag} <= w_fifo_rdata;
            case (r_state)
                ISSUE: begin
                    r_alu_a      <= r_op_a;
                    r_alu_b      <= r_op_b;
                    r_alu_op     <= r_op_op;
                    r_settle_cnt <= C_SETTLE_LOAD;
                end
                SETTLE: begin
                    if (r_settle_cnt != '0) r_settle_cnt <= r_settle_cnt - 1'b1;
                end
                CAPTURE: begin
                    r_rsp_data  <= alu_result;
                    r_rsp_tag   <= r_op_tag;
                    r_rsp_err   <= (r_op_op == OP_DIV) && (r_op_b == 8'h00);
                    r_rsp_valid <= 1'b1;
                end
                RESP: begin
                    if (rsp_ready) r_rsp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign cmd_ready = w_fifo_not_full;
    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_op    = r_alu_op;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_tag   = r_rsp_tag;
    assign rsp_err   = r_rsp_err;
    assign busy      = (r_state != IDLE) || !w_fifo_empty;

endmodule
`default_nettype wire

// File: tb/tb_alu8_cmd_issuer.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu8_cmd_issuer
// Description : Scoreboard bench for alu8_cmd_issuer with a behavioural ALU8.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu8_cmd_issuer;

    typedef struct packed {
        logic [7:0] data;
        logic [3:0] tag;
        logic       err;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_err, busy;
    logic [7:0] cmd_a, cmd_b, alu_a, alu_b, alu_result, rsp_data;
    logic [2:0] cmd_op, alu_op;
    logic [3:0] cmd_tag, rsp_tag;

    logic       cmd_valid3, cmd_ready3, rsp_valid3, rsp_ready3, rsp_err3, busy3;
    logic [7:0] cmd_a3, cmd_b3, alu_a3, alu_b3, alu_result3, rsp_data3;
    logic [2:0] cmd_op3, alu_op3;
    logic [3:0] cmd_tag3, rsp_tag3;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                           input logic [2:0] op);
        logic [15:0] p;
        case (op)
            3'b000:  return a + b;
            3'b001:  return a - b;
            3'b010:  begin p = a * b; return p[7:0]; end
            3'b011:  return (b == 8'h00) ? 8'hFF : a / b;
            default: return 8'h00;
        endcase
    endfunction

    assign alu_result  = alu_ref(alu_a, alu_b, alu_op);
    assign alu_result3 = alu_ref(alu_a3, alu_b3, alu_op3);

    alu8_cmd_issuer #(.FIFO_DEPTH(4), .SETTLE_CYCLES(1), .TAG_W(4)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_tag(cmd_tag),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_tag(rsp_tag), .rsp_err(rsp_err), .busy(busy)
    );

    alu8_cmd_issuer #(.FIFO_DEPTH(4), .SETTLE_CYCLES(3), .TAG_W(4)) dut3 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3),
        .cmd_a(cmd_a3), .cmd_b(cmd_b3), .cmd_op(cmd_op3), .cmd_tag(cmd_tag3),
        .alu_a(alu_a3), .alu_b(alu_b3), .alu_op(alu_op3), .alu_result(alu_result3),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_data(rsp_data3),
        .rsp_tag(rsp_tag3), .rsp_err(rsp_err3), .busy(busy3)
    );

    // Offers one command from a negedge; returns at the negedge after acceptance
    task automatic send_cmd(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                            input logic [3:0] tag, input bit track, input logic [7:0] exp_d,
                            input logic exp_e, input int budget, output int acc, output bit ok);
        ok = 1'b0;
        acc = 0;
        cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_op = op; cmd_tag = tag;
        for (int i = 0; i < budget; i++) begin
            if (cmd_ready) begin
                acc = cyc + 1;
                ok  = 1'b1;
                if (track) sb.push_back('{data: exp_d, tag: tag, err: exp_e});
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (rsp_valid) begin ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            n_bad++; $display("FAIL reset_flags: got ready=%b busy=%b want ready=1 busy=0", cmd_ready, busy);
        end
        n_cmp++;
        if ({alu_a, alu_b, alu_op} !== {8'h00, 8'h00, 3'b111}) begin
            n_bad++; $display("FAIL reset_alu: got a=%h b=%h op=%b want a=00 b=00 op=111", alu_a, alu_b, alu_op);
        end
        n_cmp++;
        if ({rsp_valid, rsp_data, rsp_tag, rsp_err} !== 14'h0) begin
            n_bad++; $display("FAIL reset_rsp: got v=%b d=%h t=%h e=%b want all zero", rsp_valid, rsp_data, rsp_tag, rsp_err);
        end
        n_cmp++;
        if (alu_op3 !== 3'b111 || cmd_ready3 !== 1'b1 || busy3 !== 1'b0) begin
            n_bad++; $display("FAIL reset_dut3: got op=%b ready=%b busy=%b want 111 1 0", alu_op3, cmd_ready3, busy3);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_add;
        int acc; bit ok; exp_t e;
        send_cmd(8'h12, 8'h34, 3'b000, 4'd3, 1'b1, 8'h46, 1'b0, 20, acc, ok);
        wait_rsp(20, ok);
        n_cmp++;
        if (!ok || cyc - acc != 4) begin
            n_bad++; $display("FAIL add_latency: got %0d cycles (seen=%b) want 4", cyc - acc, ok);
        end
        e = sb.pop_front();
        n_cmp++;
        if (rsp_data !== e.data || rsp_tag !== e.tag || rsp_err !== e.err) begin
            n_bad++; $display("FAIL add_rsp: got d=%h t=%h e=%b want d=%h t=%h e=%b", rsp_data, rsp_tag, rsp_err, e.data, e.tag, e.err);
        end
        @(negedge clk);
    endtask

    task automatic test_ops_and_div0;
        logic [7:0] ta [6] = '{8'h05, 8'h10, 8'hC8, 8'h5A, 8'h33, 8'h09};
        logic [7:0] tb [6] = '{8'h07, 8'h11, 8'h0A, 8'h3C, 8'h00, 8'h03};
        logic [2:0] to [6] = '{3'b001, 3'b010, 3'b011, 3'b101, 3'b011, 3'b011};
        logic [7:0] td [6] = '{8'hFE, 8'h10, 8'h14, 8'h00, 8'hFF, 8'h03};
        logic       te [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        int acc; bit ok; exp_t e;
        for (int i = 0; i < 6; i++) begin
            send_cmd(ta[i], tb[i], to[i], 4'(i + 5), 1'b1, td[i], te[i], 20, acc, ok);
            wait_rsp(20, ok);
            e = sb.pop_front();
            n_cmp++;
            if (!ok || rsp_data !== e.data || rsp_tag !== e.tag || rsp_err !== e.err) begin
                n_bad++;
                $display("FAIL op_%0d: got v=%b d=%h t=%h e=%b want d=%h t=%h e=%b", i, ok, rsp_data, rsp_tag, rsp_err, e.data, e.tag, e.err);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back;
        int t [5];
        fork
            begin
                int acc; bit ok;
                logic [7:0] a, b;
                for (int i = 0; i < 5; i++) begin
                    a = 8'(i * 29 + 7); b = 8'(i * 3 + 1);
                    send_cmd(a, b, 3'(i % 3), 4'(i + 1), 1'b1, alu_ref(a, b, 3'(i % 3)), 1'b0, 40, acc, ok);
                    n_cmp++;
                    if (!ok) begin n_bad++; $display("FAIL b2b_accept_%0d: got not accepted want accepted", i); end
                end
            end
            begin
                bit ok; exp_t e;
                for (int k = 0; k < 5; k++) begin
                    wait_rsp(40, ok);
                    t[k] = cyc;
                    e = (sb.size() > 0) ? sb.pop_front() : '0;
                    n_cmp++;
                    if (!ok || rsp_data !== e.data || rsp_tag !== e.tag || rsp_err !== e.err) begin
                        n_bad++;
                        $display("FAIL b2b_rsp_%0d: got v=%b d=%h t=%h e=%b want d=%h t=%h e=%b", k, ok, rsp_data, rsp_tag, rsp_err, e.data, e.tag, e.err);
                    end
                    @(negedge clk);
                end
            end
        join
        for (int k = 1; k < 5; k++) begin
            n_cmp++;
            if (t[k] - t[k-1] != 5) begin
                n_bad++; $display("FAIL b2b_gap_%0d: got %0d cycles want 5", k, t[k] - t[k-1]);
            end
        end
    endtask

    task automatic test_full_backpressure;
        int acc; bit ok; int n_acc; bit stable; exp_t e;
        logic [7:0] a, b; logic [2:0] op;
        rsp_ready = 1'b0;
        n_acc = 0;
        for (int i = 0; i < 6; i++) begin
            a = 8'(i * 17 + 3); b = 8'(i + 1); op = 3'(i % 4);
            send_cmd(a, b, op, 4'(i + 8), 1'b1, alu_ref(a, b, op), 1'b0, 12, acc, ok);
            if (ok) n_acc++;
        end
        n_cmp++;
        if (n_acc != 5 || cmd_ready !== 1'b0) begin
            n_bad++; $display("FAIL full_accept: got %0d accepted ready=%b want 5 accepted ready=0", n_acc, cmd_ready);
        end
        n_cmp++;
        if (busy !== 1'b1) begin n_bad++; $display("FAIL full_busy: got %b want 1", busy); end
        stable = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (rsp_valid !== 1'b1 || rsp_data !== sb[0].data || rsp_tag !== sb[0].tag || rsp_err !== sb[0].err)
                stable = 1'b0;
            @(negedge clk);
        end
        n_cmp++;
        if (!stable) begin
            n_bad++; $display("FAIL stall_hold: got v=%b d=%h t=%h want v=1 d=%h t=%h", rsp_valid, rsp_data, rsp_tag, sb[0].data, sb[0].tag);
        end
        rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wait_rsp(40, ok);
            e = (sb.size() > 0) ? sb.pop_front() : '0;
            n_cmp++;
            if (!ok || rsp_data !== e.data || rsp_tag !== e.tag || rsp_err !== e.err) begin
                n_bad++;
                $display("FAIL full_rsp_%0d: got v=%b d=%h t=%h e=%b want d=%h t=%h e=%b", k, ok, rsp_data, rsp_tag, rsp_err, e.data, e.tag, e.err);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_midop;
        int acc; bit ok; bit stale;
        for (int i = 0; i < 3; i++)
            send_cmd(8'(i + 1), 8'h02, 3'b000, 4'(i), 1'b0, 8'h00, 1'b0, 20, acc, ok);
        n_cmp++;
        if (alu_op !== 3'b000 || busy !== 1'b1) begin
            n_bad++; $display("FAIL midop_pre: got op=%b busy=%b want 000 1", alu_op, busy);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if ({rsp_valid, busy, cmd_ready, alu_op} !== {1'b0, 1'b0, 1'b1, 3'b111}) begin
            n_bad++; $display("FAIL midop_reset: got v=%b busy=%b ready=%b op=%b want 0 0 1 111", rsp_valid, busy, cmd_ready, alu_op);
        end
        stale = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (rsp_valid || busy) stale = 1'b1;
            @(negedge clk);
        end
        n_cmp++;
        if (stale) begin n_bad++; $display("FAIL midop_stale: got activity after reset want none"); end
    endtask

    task automatic test_settle3;
        int acc; bit seen; bit held;
        cmd_valid3 = 1'b1; cmd_a3 = 8'h21; cmd_b3 = 8'h05; cmd_op3 = 3'b000; cmd_tag3 = 4'd9;
        n_cmp++;
        if (cmd_ready3 !== 1'b1) begin n_bad++; $display("FAIL s3_ready: got %b want 1", cmd_ready3); end
        acc = cyc + 1;
        @(negedge clk);
        cmd_valid3 = 1'b0;
        seen = 1'b0; held = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (rsp_valid3) begin seen = 1'b1; break; end
            if (cyc - acc >= 2 && {alu_a3, alu_b3, alu_op3} !== {8'h21, 8'h05, 3'b000}) held = 1'b0;
            @(negedge clk);
        end
        n_cmp++;
        if (!seen || cyc - acc != 6) begin
            n_bad++; $display("FAIL s3_latency: got %0d cycles (seen=%b) want 6", cyc - acc, seen);
        end
        n_cmp++;
        if (!held) begin n_bad++; $display("FAIL s3_alu_hold: got operands changing want 21/05/000 held"); end
        n_cmp++;
        if (rsp_data3 !== 8'h26 || rsp_tag3 !== 4'd9 || rsp_err3 !== 1'b0) begin
            n_bad++; $display("FAIL s3_rsp: got d=%h t=%h e=%b want d=26 t=9 e=0", rsp_data3, rsp_tag3, rsp_err3);
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0; cmd_tag = '0; rsp_ready = 1'b1;
        cmd_valid3 = 1'b0; cmd_a3 = '0; cmd_b3 = '0; cmd_op3 = '0; cmd_tag3 = '0; rsp_ready3 = 1'b1;
        @(negedge clk);
        test_reset();
        test_single_add();
        test_ops_and_div0();
        test_back_to_back();
        test_full_backpressure();
        test_reset_midop();
        test_settle3();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
